// File: rtl/pla_row_sequencer.sv
// pla_row_sequencer: serial AND-plane evaluator, one product-term row per clock, with programmable care/value rows
module pla_row_sequencer #(
  parameter int NCOLS = 7,
  parameter int NROWS = 3,
  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [RW-1:0]    cfg_row,
  input  logic [NCOLS-1:0] cfg_care,
  input  logic [NCOLS-1:0] cfg_val,
  output logic             cfg_ready,
  input  logic             in_valid,
  input  logic [NCOLS-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [NROWS-1:0] out_data,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [NCOLS-1:0] din_q, din_d;
  logic [NROWS-1:0] res_q, res_d;
  logic [NCOLS-1:0] care_q [NROWS];
  logic [NCOLS-1:0] val_q [NROWS];
  logic last, match, cfg_hit;
  assign last = row_q == RW'(NROWS - 1);
  assign match = ((din_q ^ val_q[row_q]) & care_q[row_q]) == '0;
  // out-of-range rows are dropped here so storage never changes for them
  assign cfg_hit = cfg_we && state_q == IDLE && int'(cfg_row) < NROWS;
  assign cfg_ready = state_q == IDLE;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = res_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    din_d = din_q;
    res_d = res_q;
    if (state_q == IDLE && in_valid) begin
      state_d = EVAL;
      row_d = '0;
      din_d = in_data;
      res_d = '0;
    end
    if (state_q == EVAL) begin
      res_d = res_q | (NROWS'(match) << row_q);
      row_d = last ? row_q : row_q + 1'b1;
      state_d = last ? DONE : EVAL;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      din_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      din_q <= din_d;
      res_q <= res_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NROWS; r++) begin
      if (rst) begin
        care_q[r] <= '0;
        val_q[r] <= '0;
      end else if (cfg_hit && int'(cfg_row) == r) begin
        care_q[r] <= cfg_care;
        val_q[r] <= cfg_val;
      end
    end
  end
endmodule

// File: tb/tb_pla_row_sequencer.sv
// tb_pla_row_sequencer: directed checks of the PLA row sequencer with NCOLS=3, NROWS=4
module tb_pla_row_sequencer;
  localparam int NC = 3;
  localparam int NR = 4;
  logic clk = 0, rst = 1, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [1:0] cfg_row = 0;
  logic [NC-1:0] cfg_care = 0, cfg_val = 0, in_data = 0;
  logic cfg_ready, in_ready, out_valid;
  logic [NR-1:0] out_data;
  logic [NC-1:0] m_care [NR];
  logic [NC-1:0] m_val [NR];
  int vecs = 0, errs = 0;

  pla_row_sequencer #(.NCOLS(NC), .NROWS(NR)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_ready(cfg_ready), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] model(input logic [NC-1:0] d);
    logic [NR-1:0] m;
    for (int r = 0; r < NR; r++) m[r] = ((d ^ m_val[r]) & m_care[r]) == '0;
    return m;
  endfunction

  task automatic test_reset;
    rst = 1;
    step;
    step;
    rst = 0;
    for (int r = 0; r < NR; r++) begin m_care[r] = '0; m_val[r] = '0; end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vecs++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vecs++; if (out_data !== 4'b0000) begin errs++; $display("FAIL reset_out_data: got %b want 0000", out_data); end
  endtask

  task automatic write_row(input logic [1:0] r, input logic [NC-1:0] c, input logic [NC-1:0] v);
    cfg_we = 1; cfg_row = r; cfg_care = c; cfg_val = v;
    vecs++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready); end
    step;
    cfg_we = 0;
    m_care[r] = c; m_val[r] = v;
  endtask

  task automatic program_rows;
    write_row(2'd0, 3'b011, 3'b001);
    write_row(2'd1, 3'b100, 3'b100);
    write_row(2'd2, 3'b101, 3'b000);
    write_row(2'd3, 3'b000, 3'b000);
  endtask

  // accept at edge T, result first seen after edge T+NR, i.e. valid when edge T+NR+1 samples it
  task automatic run_vec(input logic [NC-1:0] d, input logic [NR-1:0] exp, input string nm);
    in_valid = 1; in_data = d; out_ready = 0;
    step;
    in_valid = 0; in_data = ~d;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL %s_busy: in_ready got %b want 0", nm, in_ready); end
    repeat (NR - 1) step;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL %s_early: out_valid got %b want 0", nm, out_valid); end
    step;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL %s_valid: out_valid got %b want 1", nm, out_valid); end
    vecs++; if (out_data !== exp) begin errs++; $display("FAIL %s_data: got %b want %b", nm, out_data, exp); end
    out_ready = 1;
    step;
    out_ready = 0;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL %s_release: out_valid %b in_ready %b want 0 1", nm, out_valid, in_ready); end
  endtask

  task automatic test_unprogrammed;
    run_vec(3'b101, 4'b1111, "unprog_101");
  endtask

  task automatic test_program;
    program_rows;
    run_vec(3'b111, 4'b1010, "prog_111");
    run_vec(3'b000, 4'b1100, "prog_000");
    run_vec(3'b101, 4'b1011, "prog_101");
  endtask

  task automatic test_stall;
    in_valid = 1; in_data = 3'b111; out_ready = 0;
    step;
    in_valid = 0; in_data = 3'b000;
    repeat (NR) step;
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_data !== 4'b1010 || in_ready !== 1'b0) begin
        errs++; $display("FAIL stall_hold%0d: valid %b data %b in_ready %b want 1 1010 0", i, out_valid, out_data, in_ready);
      end
      step;
    end
    out_ready = 1;
    step;
    out_ready = 0;
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL stall_release: in_ready %b valid %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_cfg_drop;
    in_valid = 1; in_data = 3'b000; out_ready = 0;
    step;
    in_valid = 0;
    cfg_we = 1; cfg_row = 2'd1; cfg_care = 3'b000; cfg_val = 3'b000;
    vecs++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL cfg_busy: cfg_ready got %b want 0", cfg_ready); end
    step;
    cfg_we = 0;
    repeat (NR - 1) step;
    vecs++; if (out_data !== 4'b1100) begin errs++; $display("FAIL cfg_drop_same: got %b want 1100", out_data); end
    out_ready = 1;
    step;
    out_ready = 0;
    run_vec(3'b000, 4'b1100, "cfg_drop_later");
    cfg_we = 1; cfg_row = 2'd3; cfg_care = 3'b001; cfg_val = 3'b001;
    in_valid = 1; in_data = 3'b000;
    vecs++; if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin errs++; $display("FAIL cfg_simul_ready: cfg %b in %b want 1 1", cfg_ready, in_ready); end
    step;
    cfg_we = 0; in_valid = 0;
    m_care[3] = 3'b001; m_val[3] = 3'b001;
    repeat (NR) step;
    vecs++; if (out_data !== 4'b0100) begin errs++; $display("FAIL cfg_simul_data: got %b want 0100", out_data); end
    out_ready = 1;
    step;
    out_ready = 0;
  endtask

  task automatic test_mid_reset;
    in_valid = 1; in_data = 3'b000;
    step;
    in_valid = 0;
    step;
    rst = 1;
    step;
    rst = 0;
    for (int r = 0; r < NR; r++) begin m_care[r] = '0; m_val[r] = '0; end
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL midrst_state: valid %b in_ready %b want 0 1", out_valid, in_ready); end
    run_vec(3'b000, 4'b1111, "midrst_cleared");
  endtask

  task automatic test_back_to_back;
    logic [NR-1:0] exp_q [$];
    logic [NC-1:0] pat [6];
    int acc_n, out_n, last_acc;
    logic [NR-1:0] e;
    pat[0] = 3'b111; pat[1] = 3'b000; pat[2] = 3'b101;
    pat[3] = 3'b010; pat[4] = 3'b110; pat[5] = 3'b001;
    program_rows;
    acc_n = 0; out_n = 0; last_acc = -1;
    in_valid = 1; out_ready = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_data = pat[acc_n % 6];
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vecs++; if (out_data !== e) begin errs++; $display("FAIL b2b_data%0d: got %b want %b", out_n, out_data, e); end
        out_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        if (last_acc >= 0) begin
          vecs++; if (cyc - last_acc != 6) begin errs++; $display("FAIL b2b_period: got %0d want 6", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_n++;
      end
      step;
    end
    in_valid = 0; out_ready = 0;
    vecs++; if (acc_n != 7 || out_n != 6) begin errs++; $display("FAIL b2b_count: accepts %0d results %0d want 7 6", acc_n, out_n); end
  endtask

  initial begin
    test_reset;
    test_unprogrammed;
    test_program;
    test_stall;
    test_cfg_drop;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
